netlist_bist_ctrl: RTL and testbench



---
 rtl/netlist_bist_ctrl.sv | 94 +++++++++
 tb/tb_netlist_bist_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/netlist_bist_ctrl.sv
// Logic BIST controller: LFSR stimulus into a combinational netlist, MISR compaction of its outputs, golden compare.
// Latency: start at edge k -> busy for PATTERNS cycles, done from edge k+PATTERNS+1; pass is combinational in DONE.
// Backpressure: none; start is ignored while running, abort cancels a run from any state.
module netlist_bist_ctrl #(
    parameter int               IN_W      = 14,
    parameter int               OUT_W     = 8,
    parameter int               PATTERNS  = 1024,
    parameter logic [IN_W-1:0]  SEED      = 14'h0001,
    parameter logic [IN_W-1:0]  LFSR_POLY = 14'h3005,
    parameter logic [OUT_W-1:0] MISR_POLY = 8'h71
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // A zero seed would lock the LFSR at zero, so it is substituted.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
    localparam logic [15:0]     CNT_LAST = 16'(PATTERNS - 1);

    state_t           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [OUT_W-1:0] misr_q, misr_d;
    logic [15:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_d  = SEED_EFF;
                        misr_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // dut_out here is the response to the current lfsr_q, which drives dut_in.
                    misr_d = {misr_q[OUT_W-2:0], 1'b0}
                           ^ (misr_q[OUT_W-1] ? MISR_POLY : '0)
                           ^ dut_out;
                    lfsr_d = {lfsr_q[IN_W-2:0], 1'b0}
                           ^ (lfsr_q[IN_W-1] ? LFSR_POLY : '0);
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dut_in    = lfsr_q;
    assign signature = misr_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (misr_q == golden);

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
module tb_netlist_bist_ctrl;

    localparam int P = 1024;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [7:0]  golden;
    logic [13:0] dut_in;
    logic [7:0]  dut_out_w;
    logic        busy, done, pass;
    logic [7:0]  signature;

    logic        s_start, s_abort;
    logic [7:0]  s_gold, s_out, s_sig;
    logic [13:0] s_in;
    logic        s_busy, s_done, s_pass;

    logic [31:0] net_key;
    logic        fault_en;
    logic [13:0] fault_vec;
    logic [7:0]  fault_mask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        int         busy_cycles;
    } exp_t;
    exp_t sb_q[$];

    netlist_bist_ctrl #(.PATTERNS(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
        .dut_in(dut_in), .dut_out(dut_out_w), .busy(busy), .done(done),
        .pass(pass), .signature(signature)
    );

    netlist_bist_ctrl #(.PATTERNS(2), .SEED(14'h0000)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .golden(s_gold),
        .dut_in(s_in), .dut_out(s_out), .busy(s_busy), .done(s_done),
        .pass(s_pass), .signature(s_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference netlist standing in for the gate-level block: XOR cones plus one AND term per output.
    function automatic logic [7:0] ref_net(input logic [13:0] x, input logic [31:0] key);
        logic [7:0]  o;
        logic [63:0] kk;
        logic [13:0] m;
        kk = {key, key};
        for (int j = 0; j < 8; j++) begin
            m    = 14'(kk >> (3 * j));
            o[j] = (^(x & m)) ^ (x[j] & x[j+5]);
        end
        return o;
    endfunction

    always_comb begin
        dut_out_w = ref_net(dut_in, net_key);
        if (fault_en && dut_in == fault_vec) dut_out_w = dut_out_w ^ fault_mask;
    end

    // GF(2) polynomial remainder of a modulo m, where m has degree deg.
    function automatic logic [31:0] pmod(input logic [31:0] a, input logic [31:0] m, input int deg);
        logic [31:0] r;
        r = a;
        for (int b = 31; b >= deg; b--)
            if (r[b]) r = r ^ (m << (b - deg));
        return r;
    endfunction

    function automatic logic [31:0] clmul(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] acc;
        acc = 0;
        for (int i = 0; i < 8; i++)
            if (b[i]) acc = acc ^ (32'(a) << i);
        return acc;
    endfunction

    // Vector idx of the run is seed * x^idx mod the LFSR polynomial.
    function automatic logic [13:0] model_vec(input int idx);
        logic [31:0] v;
        v = 1;
        for (int i = 0; i < idx; i++) v = pmod(v << 1, 32'h7005, 14);
        return v[13:0];
    endfunction

    // Signature = sum over responses r_i * x^(P-1-i) mod the MISR polynomial.
    function automatic logic [7:0] model_sig(input logic [31:0] key, input bit fen,
                                             input logic [13:0] fv, input logic [7:0] fm);
        logic [31:0] xp[];
        logic [31:0] v, acc;
        logic [7:0]  r;
        xp    = new[P];
        xp[0] = 1;
        for (int k = 1; k < P; k++) xp[k] = pmod(xp[k-1] << 1, 32'h171, 8);
        v   = 1;
        acc = 0;
        for (int i = 0; i < P; i++) begin
            r = ref_net(v[13:0], key);
            if (fen && v[13:0] == fv) r = r ^ fm;
            acc = acc ^ pmod(clmul(r, xp[P-1-i][7:0]), 32'h171, 8);
            v   = pmod(v << 1, 32'h7005, 14);
        end
        return acc[7:0];
    endfunction

    // Scoreboard monitor: checks every completed run on the rising edge of done.
    int  bcnt = 0, last_busy = 0;
    bit  done_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt      = 0;
            done_prev = 0;
        end else begin
            if (busy) bcnt++;
            else begin
                if (bcnt != 0) last_busy = bcnt;
                bcnt = 0;
            end
            if (done && !done_prev) begin
                chk("sb_entry_present", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_signature", signature, e.sig);
                    chk("sb_pass", pass, e.pass);
                    chk("sb_busy_cycles", last_busy, e.busy_cycles);
                end
            end
            done_prev = done;
        end
    end

    task automatic launch(input logic [31:0] key, input bit fen, input int fidx,
                          input bit rand_gold, input bit push);
        logic [7:0]  clean, expv, fm;
        logic [13:0] fv;
        fv    = model_vec(fidx);
        fm    = 8'(1 << $urandom_range(7, 0));
        clean = model_sig(key, 1'b0, 14'h0, 8'h0);
        expv  = fen ? model_sig(key, 1'b1, fv, fm) : clean;
        net_key    = key;
        fault_en   = fen;
        fault_vec  = fv;
        fault_mask = fm;
        golden     = rand_gold ? 8'($urandom) : clean;
        if (push) sb_q.push_back('{sig: expv, pass: (golden == expv), busy_cycles: P});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < P + 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, done, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] key;
        logic [7:0]  prev_sig;
        bit          fen;
        int          mid;
        rst_n = 1'b1; start = 0; abort = 0; golden = 0;
        s_start = 0; s_abort = 0; s_gold = 0; s_out = 0;
        net_key = 32'h1234_5678; fault_en = 0; fault_vec = 0; fault_mask = 0;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_signature", signature, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LFSR sequence from SEED=1: powers of two, then the first feedback term.
        launch(32'hA5C3_0F17, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("lfsr_vec%0d", i), dut_in, (i < 14) ? (32'd1 << i) : 32'h3005);
            @(negedge clk);
        end
        wait_done("done_run_lfsr");

        // Two-pattern instance with a zero seed parameter.
        s_out = 8'h01; s_gold = 8'h03;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("small_seed_subst", s_in, 1);
        chk("small_busy", s_busy, 1);
        @(negedge clk);
        chk("small_not_done_edge2", s_done, 0);
        @(negedge clk);
        chk("small_done_edge3", s_done, 1);
        chk("small_sig_01", s_sig, 8'h03);
        chk("small_pass_03", s_pass, 1);
        s_gold = 8'h04;
        #1 chk("small_pass_04", s_pass, 0);
        @(negedge clk);
        s_out = 8'h00; s_gold = 8'h00;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("small_sig_00", s_sig, 8'h00);
        chk("small_pass_00", s_pass, 1);

        // Randomized runs, restarted straight from DONE, with stray starts mid-run.
        for (int r = 0; r < 4; r++) begin
            key = $urandom;
            fen = ($urandom_range(1, 0) == 1);
            launch(key, fen, $urandom_range(P - 1, 0), ($urandom_range(1, 0) == 1), 1'b1);
            mid = $urandom_range(900, 1);
            repeat (mid) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done($sformatf("done_rand%0d", r));
        end

        // Clean run, identical restart, then the same netlist with one flipped bit.
        key = $urandom;
        launch(key, 1'b0, 0, 1'b0, 1'b1);
        wait_done("done_clean");
        prev_sig = signature;
        launch(key, 1'b0, 0, 1'b0, 1'b1);
        wait_done("done_restart");
        chk("restart_same_sig", signature, prev_sig);
        launch(key, 1'b1, $urandom_range(P - 1, 0), 1'b0, 1'b1);
        wait_done("done_fault");
        chk("fault_sig_differs", 32'(signature != prev_sig), 1);
        chk("fault_pass_low", pass, 0);

        // Abort with a simultaneous start on RUN cycle 5, then a full rerun.
        launch(key, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        launch(key, 1'b0, 0, 1'b0, 1'b1);
        wait_done("done_after_abort");
        chk("abort_rerun_sig", signature, prev_sig);

        // Asynchronous reset in the middle of a run.
        launch(key, 1'b0, 0, 1'b0, 1'b0);
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dut_in", dut_in, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_signature", signature, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
